// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/FA.sv
// Single-bit full adder cell, purely combinational.
module FA (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one FA cell plus registered carry, LSB first, WIDTH cycles per add.
// Latency start-accept to done is WIDTH cycles; start is ignored while busy (no queuing).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;

    assign last_bit = (cnt == LAST);

    FA u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Result shifts in at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            res_sh <= {fa_s, res_sh[WIDTH-1:1]};
            carry  <= fa_co;
            cnt    <= cnt + 1'b1;
            // Sum is a separate register so it never ripples while bits are in flight.
            if (last_bit) begin
                Sum  <= {fa_s, res_sh[WIDTH-1:1]};
                Cout <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: cycle-level reference model plus literal spot checks.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         Cin   = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;

    logic         start2 = 1'b0;
    logic         cin2   = 1'b0;
    logic [1:0]   a2     = '0;
    logic [1:0]   b2     = '0;
    logic         busy2;
    logic         done2;
    logic [1:0]   sum2;
    logic         cout2;

    int n_vec = 0;
    int n_bad = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .Cin(cin2),
        .busy(busy2), .done(done2), .Sum(sum2), .Cout(cout2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start opens a busy window of W+1 cycles,
    // the last of which carries done and publishes A+B+Cin computed arithmetically.
    int           rem     = 0;
    logic [W:0]   pend    = '0;
    logic [W:0]   exp_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     = 0;
            exp_res = '0;
        end else if (rem > 0) begin
            rem = rem - 1;
            if (rem == 1) exp_res = pend;
        end else if (start) begin
            rem  = W + 1;
            pend = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, rem > 0});
        chk("done", {31'b0, done}, {31'b0, rem == 1});
        chk("sum",  {24'b0, Sum},  {24'b0, exp_res[W-1:0]});
        chk("cout", {31'b0, Cout}, {31'b0, exp_res[W]});
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        A = a; B = b; Cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    endtask

    task automatic wait_done(input string nm, input logic [W:0] lit);
        int lat;
        lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(negedge clk);
            #1;
            if (done) lat = i;
        end
        if (lat == 0) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_lat"},  lat, W);
            chk({nm, "_sum"},  {24'b0, Sum}, {24'b0, lit[W-1:0]});
            chk({nm, "_cout"}, {31'b0, Cout}, {31'b0, lit[W]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int done_cnt, done_at, busy_cnt, last_done;
        logic [W-1:0] ra, rb;
        logic         rc;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_sum",  {24'b0, Sum},  0);
        chk("rst_cout", {31'b0, Cout}, 0);
        rst = 1'b0;

        // 3C+05 with an intruding start in cycle 3 that must be ignored
        issue(8'h3C, 8'h05, 1'b0);
        done_cnt = 0; done_at = 0; busy_cnt = busy ? 1 : 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 3) begin
                start = 1'b1; A = 8'h10; B = 8'h20;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (busy) busy_cnt++;
        end
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_done_at",  done_at,  W);
        chk("ign_busy_cnt", busy_cnt, W + 1);
        chk("ign_sum",      {24'b0, Sum},  32'h41);
        chk("ign_cout",     {31'b0, Cout}, 0);

        issue(8'hFF, 8'h01, 1'b0);
        wait_done("ff01", 9'h100);
        issue(8'hFF, 8'hFF, 1'b1);
        wait_done("ffff1", 9'h1FF);

        // asynchronous reset between edges 4 and 5 of an operation
        issue(8'h3C, 8'h05, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_done", {31'b0, done}, 0);
        chk("mid_rst_sum",  {24'b0, Sum},  0);
        chk("mid_rst_cout", {31'b0, Cout}, 0);
        @(negedge clk);
        rst = 1'b0;
        issue(8'h01, 8'h01, 1'b0);
        wait_done("post_rst", 9'h002);

        // start held high: back-to-back operations every W+2 cycles
        @(negedge clk);
        start = 1'b1;
        last_done = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            if (done) begin
                if (last_done != 0) chk("held_period", c - last_done, W + 2);
                last_done = c;
            end
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            issue(ra, rb, rc);
            wait_done("rand", {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
        end

        // narrowest legal width
        @(negedge clk);
        a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;
        done_at = 0;
        for (int c = 1; c <= 10 && done_at == 0; c++) begin
            @(negedge clk);
            if (done2) done_at = c;
        end
        chk("w2_lat",  done_at, 2);
        chk("w2_sum",  {30'b0, sum2},  32'h3);
        chk("w2_cout", {31'b0, cout2}, 1);
        @(negedge clk);
        chk("w2_idle", {31'b0, busy2}, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
